sender: RTL and testbench

SENDER -- requirements
Module: sender

---
 rtl/handshake_pkg.sv | 14 +
 rtl/sender.sv | 111 +++++++++++
 tb/tb_sender.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/handshake_pkg.sv
// Shared handshake definitions: FSM state encoding and default sizing,
// common to the sender and receiver stages.
package handshake_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } hs_state_e;

  localparam int unsigned HS_DATA_WIDTH = 8;
  localparam int unsigned HS_DEPTH      = 16;

endpackage

// File: rtl/sender.sv
// Burst sender: emits len consecutive words base, base+1, ... over a
// valid/ready handshake, throttled by valid_test, then pulses done.
module sender
  import handshake_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = HS_DATA_WIDTH,
  parameter int unsigned DEPTH      = HS_DEPTH,
  parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  input  logic [DATA_WIDTH-1:0] base,
  input  logic                  valid_test,
  input  logic                  ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   sent_cnt
);

  localparam int unsigned CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  hs_state_e             state_q, state_d;
  logic [CW-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]         cnt_inc;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    data_d  = data_q;
    cnt_inc = cnt_q + CW'(1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d = base;
          cnt_d  = '0;
          if (len == '0) begin
            len_d   = '0;
            valid_d = 1'b0;
            state_d = ST_DONE;
          end else begin
            len_d   = (len > DEPTH_C) ? DEPTH_C : len;
            data_d  = base;
            valid_d = valid_test;
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (valid_q && ready) begin
          cnt_d = cnt_inc;
          if (cnt_inc == len_q) begin
            valid_d = 1'b0;
            state_d = ST_DONE;
          end else if (valid_test) begin
            valid_d = 1'b1;
            data_d  = base_q + DATA_WIDTH'(cnt_inc);
          end else begin
            valid_d = 1'b0;
          end
        end else if (!valid_q && valid_test) begin
          // Word index is the accepted count, so a throttled gap never skips data.
          valid_d = 1'b1;
          data_d  = base_q + DATA_WIDTH'(cnt_q);
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid    = valid_q;
  assign data     = data_q;
  assign sent_cnt = cnt_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sender.sv
// Scoreboard bench for sender: expected words are queued at burst start
// and popped by a negedge monitor on every handshake.
module tb_sender;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [4:0] len;
  logic [7:0] base;
  logic       valid_test;
  logic       ready;
  logic       valid;
  logic [7:0] data;
  logic       busy;
  logic       done;
  logic [4:0] sent_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [7:0] exp_q[$];
  bit         rdy_pat[64];
  bit         vt_pat[64];

  sender #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .len        (len),
    .base       (base),
    .valid_test (valid_test),
    .ready      (ready),
    .valid      (valid),
    .data       (data),
    .busy       (busy),
    .done       (done),
    .sent_cnt   (sent_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit rp(input int i);
    return (i < 64) ? rdy_pat[i] : 1'b1;
  endfunction

  function automatic bit vp(input int i);
    return (i < 64) ? vt_pat[i] : 1'b1;
  endfunction

  task automatic pats_all_high();
    for (int i = 0; i < 64; i++) begin
      rdy_pat[i] = 1'b1;
      vt_pat[i]  = 1'b1;
    end
  endtask

  // Monitor: data order, hold-until-transfer, single-cycle done.
  logic       prev_v, prev_x, prev_rst, prev_done;
  logic [7:0] prev_d;
  initial begin
    prev_v = 1'b0; prev_x = 1'b0; prev_rst = 1'b0; prev_done = 1'b0; prev_d = '0;
  end
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (exp_q.size() == 0) chk("extra_xfer", {31'd0, valid}, 32'd0);
      else                   chk("xfer_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
    end
    if (prev_rst && prev_v && !prev_x) begin
      chk("hold_valid", {31'd0, valid}, 32'd1);
      chk("hold_data", {24'd0, data}, {24'd0, prev_d});
    end
    if (done) chk("done_width", {31'd0, prev_done}, 32'd0);
    prev_v    = valid;
    prev_x    = rst_n && valid && ready;
    prev_rst  = rst_n;
    prev_d    = data;
    prev_done = done;
  end

  task automatic burst(input logic [7:0] b, input logic [4:0] l, input int exp_n,
                       input int exp_lat, input bit mid_start);
    int  edges;
    bit  seen;
    for (int i = 0; i < exp_n; i++) exp_q.push_back(b + 8'(i));
    @(posedge clk); #1;
    start = 1'b1; len = l; base = b;
    ready = rp(0); valid_test = vp(0);
    edges = 0; seen = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) chk("first_valid", {31'd0, valid}, {31'd0, vt_pat[0] && (l != 5'd0)});
      start = mid_start && (edges == 1);
      if (mid_start) begin
        len  = 5'd2;
        base = 8'h55;
      end
      ready      = rp(edges);
      valid_test = vp(edges);
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    if (!seen) chk("timeout", {31'd0, done}, 32'd1);
    if (exp_lat > 0) chk("done_lat", edges, exp_lat);
    chk("sent_cnt", {27'd0, sent_cnt}, exp_n);
    chk("busy_in_done", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("idle", {31'd0, busy}, 32'd0);
    chk("cnt_hold", {27'd0, sent_cnt}, exp_n);
    chk("q_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; base = '0; valid_test = 1'b0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_data", {24'd0, data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", {27'd0, sent_cnt}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back burst with latency check
    pats_all_high();
    burst(8'h10, 5'd4, 4, 5, 1'b0);

    // Ready stalled for three cycles while a word is offered
    pats_all_high();
    for (int i = 0; i < 4; i++) rdy_pat[i] = 1'b0;
    burst(8'h30, 5'd3, 3, -1, 1'b0);

    // Throttle toggling: gaps in valid, no skipped words
    pats_all_high();
    for (int i = 0; i < 64; i++) vt_pat[i] = (i % 2 == 0);
    burst(8'hA0, 5'd4, 4, -1, 1'b0);

    // Empty burst and clamped oversize burst
    pats_all_high();
    burst(8'h77, 5'd0, 0, 1, 1'b0);
    burst(8'h00, 5'd20, 16, 17, 1'b0);

    // Wrap past 8'hFF, with a second start issued mid-burst
    burst(8'hFE, 5'd3, 3, -1, 1'b1);

    // Reset after two of eight words
    exp_q.push_back(8'h40);
    exp_q.push_back(8'h41);
    @(posedge clk); #1;
    start = 1'b1; len = 5'd8; base = 8'h40; ready = 1'b1; valid_test = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_cnt", {27'd0, sent_cnt}, 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("abort_valid", {31'd0, valid}, 32'd0);
    chk("abort_cnt", {27'd0, sent_cnt}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", {31'd0, done}, 32'd0);
      @(posedge clk); #1;
    end
    chk("abort_q_empty", exp_q.size(), 32'd0);
    burst(8'hC3, 5'd5, 5, 6, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
